// File: rtl/dmem_access_unit.sv
// dmem_access_unit
//
// Memory-stage data-memory responder. It takes the load/store held in the
// EX/MEM register and runs it as one transaction on a req/gnt/rvalid bus.
// It aligns store data onto byte lanes, extracts and extends load data,
// rejects misaligned or illegal accesses, and gives up on a bus that does
// not answer within MAX_WAIT cycles. The pipeline is stalled while a
// transaction is outstanding.
//
// Handshake: a request is accepted by the bus in any cycle where bus_req and
// bus_gnt are both high. bus_* request fields stay stable from the first REQ
// cycle until that grant. Read data is taken in the first WAIT cycle that has
// bus_rvalid high. gnt/rvalid seen outside REQ/WAIT are ignored.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   mem_MemRead/MemWrite  load / store request (store wins if both)
//   mem_funct3            access size / signedness
//   mem_alu_result        byte address
//   mem_write_data        store datum in the low bits
//   bus_req/we/addr/wdata/wstrb   bus request side
//   bus_gnt/rvalid/rdata          bus response side
//   mem_stall             holds the pipeline this cycle
//   mem_load_data         extended load result (held until the next load)
//   mem_load_valid        one-cycle pulse in DONE for completed loads
//   mem_access_fault      misaligned address or illegal funct3 (combinational)
//   mem_timeout           one-cycle pulse in DONE for an abandoned access

module dmem_access_unit #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_MemRead,
    input  logic        mem_MemWrite,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_write_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        mem_stall,
    output logic [31:0] mem_load_data,
    output logic        mem_load_valid,
    output logic        mem_access_fault,
    output logic        mem_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Counter value during the MAX_WAIT-th REQ/WAIT cycle.
    localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] load_data_q, load_data_d;
    logic        done_load_q, done_load_d;
    logic        done_to_q, done_to_d;

    // ------------------------------------------------------------------
    // Request decode (IDLE only)
    // ------------------------------------------------------------------
    logic        req_in;
    logic        legal;
    logic        misaligned;
    logic        accept;
    logic        fault;
    logic [1:0]  off;
    logic [3:0]  lane_strb;
    logic [31:0] lane_data;

    always_comb begin
        req_in     = mem_MemRead | mem_MemWrite;
        off        = mem_alu_result[1:0];
        legal      = 1'b0;
        misaligned = 1'b0;
        lane_strb  = 4'b0000;
        lane_data  = mem_write_data;

        // Stores have no unsigned variants, so only 000/001/010 are legal.
        case (mem_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~mem_MemWrite;
            default:                legal = 1'b0;
        endcase

        case (mem_funct3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase

        case (mem_funct3[1:0])
            2'b00: begin
                lane_strb = 4'b0001 << off;
                lane_data = {4{mem_write_data[7:0]}};
            end
            2'b01: begin
                lane_strb = 4'b0011 << off;
                lane_data = {2{mem_write_data[15:0]}};
            end
            default: begin
                lane_strb = 4'b1111;
                lane_data = mem_write_data;
            end
        endcase

        // Gating with reset keeps stall/fault low while reset is held even
        // if the EX/MEM register still presents a request.
        accept = (state_q == ST_IDLE) && !reset && req_in && legal && !misaligned;
        fault  = (state_q == ST_IDLE) && !reset && req_in && !(legal && !misaligned);
    end

    // ------------------------------------------------------------------
    // Load extraction from the captured address and size
    // ------------------------------------------------------------------
    logic [31:0] shifted;
    logic [31:0] load_ext;

    always_comb begin
        shifted = bus_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = bus_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = 8'd0;
        addr_d      = addr_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        load_data_d = load_data_q;
        done_load_d = done_load_q;
        done_to_d   = done_to_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_REQ;
                    addr_d   = mem_alu_result;
                    we_d     = mem_MemWrite;
                    funct3_d = mem_funct3;
                    wdata_d  = lane_data;
                    wstrb_d  = mem_MemWrite ? lane_strb : 4'b0000;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (bus_gnt && we_q) begin
                    state_d     = ST_DONE;
                    done_load_d = 1'b0;
                    done_to_d   = 1'b0;
                end else if (cnt_q >= LAST_CNT) begin
                    // A read granted in the final cycle still has no data.
                    state_d     = ST_DONE;
                    done_load_d = 1'b0;
                    done_to_d   = 1'b1;
                    load_data_d = 32'd0;
                end else if (bus_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (bus_rvalid) begin
                    state_d     = ST_DONE;
                    done_load_d = 1'b1;
                    done_to_d   = 1'b0;
                    load_data_d = load_ext;
                end else if (cnt_q >= LAST_CNT) begin
                    state_d     = ST_DONE;
                    done_load_d = 1'b0;
                    done_to_d   = 1'b1;
                    load_data_d = 32'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            addr_q      <= 32'd0;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            load_data_q <= 32'd0;
            done_load_q <= 1'b0;
            done_to_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            load_data_q <= load_data_d;
            done_load_q <= done_load_d;
            done_to_q   <= done_to_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus_req          = (state_q == ST_REQ);
    assign bus_we           = we_q;
    assign bus_addr         = {addr_q[31:2], 2'b00};
    assign bus_wdata        = wdata_q;
    assign bus_wstrb        = bus_req ? wstrb_q : 4'b0000;
    assign mem_stall        = accept || (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign mem_load_data    = load_data_q;
    assign mem_load_valid   = (state_q == ST_DONE) && done_load_q;
    assign mem_timeout      = (state_q == ST_DONE) && done_to_q;
    assign mem_access_fault = fault;

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Memory-stage data-memory responder: consumes the load/store request presented by the EX/MEM pipeline register and runs it as one transaction on a req/gnt/rvalid data bus. It performs store byte-lane alignment, load extraction with sign or zero extension, alignment checking and a bus timeout. It asserts a stall back to the pipeline while a transaction is outstanding. It sits between the EX/MEM register outputs and the MEM/WB register inputs.

## Interface
- MAX_WAIT, 16: maximum number of cycles spent in REQ+WAIT before the access is abandoned; legal range 2..255.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_MemRead  in  1  load request from the EX/MEM register.
- mem_MemWrite  in  1  store request; has priority if both request inputs are high.
- mem_funct3  in  3  access size: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; all other codes are illegal.
- mem_alu_result  in  32  byte address.
- mem_write_data  in  32  store data, with the datum in the low bits.
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address {addr[31:2],2'b00}.
- bus_wdata  out  32  lane-replicated store data.
- bus_wstrb  out  4  byte enables; forced to 0 whenever bus_req=0.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read data.
- mem_stall  out  1  holds the pipeline (including EX/MEM) this cycle.
- mem_load_data  out  32  extended load result.
- mem_load_valid  out  1  one-cycle pulse marking mem_load_data valid.
- mem_access_fault  out  1  misaligned address or illegal funct3.
- mem_timeout  out  1  one-cycle pulse when an access is abandoned.

## Operation
- Request = mem_MemRead | mem_MemWrite.
- Misaligned: word access with addr[1:0]≠0, or halfword access with addr[0]≠0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Request that is legal and aligned: capture addr, we, funct3, lane data and wstrb; go to REQ. mem_stall=1 combinationally in this cycle.
  - Request that is illegal or misaligned: mem_access_fault=1 combinationally, mem_stall=0, no bus activity, stay in IDLE.
- REQ:
  - bus_req=1; bus_* are driven from the capture registers and are stable until grant.
  - On bus_gnt with we=1: go to DONE.
  - On bus_gnt with we=0: go to WAIT.
  - bus_rvalid is ignored in REQ.
- WAIT: on bus_rvalid, register the extracted load into mem_load_data and go to DONE.
- DONE:
  - mem_stall=0. mem_load_valid=1 for completed loads only. mem_timeout=1 if the access was abandoned.
  - Request inputs are ignored; this is still the same instruction.
  - Always go to IDLE next.
- Timeout:
  - A cycle counter clears in IDLE and increments in each REQ/WAIT cycle.
  - If the MAX_WAIT-th REQ/WAIT cycle ends without a gnt (for a write) or rvalid (for a read), go to DONE with timeout: mem_load_data=0, mem_load_valid=0, bus_req drops.
  - A completion in that same final cycle wins over the timeout.
- mem_stall=1 in REQ and WAIT.
- Store lanes:
  - SB: wstrb = 0001<<addr[1:0], wdata = {4{wd[7:0]}}.
  - SH: wstrb = 0011<<addr[1:0], wdata = {2{wd[15:0]}}.
  - SW: wstrb = 1111, wdata = wd.
- Load extraction:
  - Shift rdata right by 8*addr[1:0], take the low byte or halfword.
  - Sign-extend for LB/LH, zero-extend for LBU/LHU; LW passes rdata through.
- bus_rvalid/bus_gnt seen in IDLE or DONE are ignored.

## Timing
- Reset (async): state IDLE, counter 0, all registered outputs 0.
  - Every output reads 0 during reset and after release until a request arrives: bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, mem_stall, mem_load_data, mem_load_valid, mem_access_fault, mem_timeout.
- Reset mid-transaction: bus_req and mem_stall fall immediately. Late responses arriving after release are ignored.
- Load latency with gnt on the first REQ cycle and rvalid on the next cycle: 3 stall cycles (IDLE, REQ, WAIT), then DONE with load data. Each extra bus wait cycle adds one stall cycle.
- Store with immediate grant: 2 stall cycles (IDLE, REQ), then DONE.
- mem_load_data holds its value from DONE until the next load completes.
- The pipeline advances at the clock edge ending DONE (stall=0). A back-to-back access is accepted in the following IDLE cycle.

## Test plan
- LW, addr 0x100, gnt in the first REQ cycle, rvalid next cycle with rdata 0xDEADBEEF -> mem_stall high 3 cycles; DONE shows mem_load_valid=1 and mem_load_data=0xDEADBEEF.
- rdata 0x80FF1234 for each load size:
  - LB at 0x103 -> 0xFFFFFF80
  - LBU at 0x103 -> 0x00000080
  - LH at 0x102 -> 0xFFFF80FF
  - LHU at 0x102 -> 0x000080FF
- SB, addr 0x201, write data 0x000000AB, gnt delayed 2 cycles -> bus_addr 0x200, bus_wstrb 0010, bus_wdata 0xABABABAB, bus_we 1, all stable while bus_req is high for 2 cycles; stall 3 cycles; no load_valid.
- LW at 0x102 and funct3=011 at 0x100 -> mem_access_fault=1 in the same cycle, mem_stall=0, bus_req never asserts.
- MAX_WAIT=4, gnt never asserted -> bus_req high 4 cycles, then DONE with mem_timeout=1, mem_load_data=0, mem_load_valid=0.
- Reset asserted in WAIT -> bus_req and mem_stall go 0 immediately; an rvalid arriving after release is ignored; the next LW completes normally.
